// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor, {sign, exp, frac}.
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Special operands (NaN/inf) skip the datapath and go straight to DONE.
// Optional macro FP_ADDSUB_RNE_EN: round-to-nearest-even in ROUND;
// when undefined, ROUND truncates. Cycle timing is identical in both builds.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int FW = 1 + EXP_W + MAN_W;   // packed operand width
    localparam int MW = MAN_W + 1;           // significand incl. hidden bit
    localparam int GW = MW + 3;              // significand + guard/round/sticky
    localparam int EW = EXP_W + 2;           // exponent with carry headroom
    localparam int CW = $clog2(MAN_W + 4);   // alignment shift counter

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_MAX  = {2'b00, EXP_ONES};
    localparam logic [EW-1:0]    EXP_ONE  = EW'(1);
    localparam logic [EW-1:0]    EXP_TWO  = EW'(2);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(MAN_W + 3);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [FW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;        // sign of the larger magnitude
    logic              zsign_q, zsign_d;      // sign to use if the sum is exactly zero
    logic              zops_q, zops_d;        // both operands were zero
    logic              sub_q, sub_d;          // effective subtraction
    logic [EW-1:0]     exp_q, exp_d;
    logic [GW-1:0]     mbig_q, mbig_d;        // larger significand, later the working sum
    logic [GW-1:0]     msml_q, msml_d;        // smaller significand being aligned
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // operand unpacking
    logic              sa, sb_eff;
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff, d;
    logic [MAN_W-1:0]  fa, fb;
    logic [GW-1:0]     ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf, special, a_big, accept;
    logic [CW-1:0]     cnt_init;
    logic [FW-1:0]     spec_res;

    // datapath helpers
    logic [GW:0]       add_sum;
    logic              rnd_up;
    logic [MW:0]       rnd_sum;
    logic              rnd_carry;
    logic [MW-1:0]     rnd_man;
    logic [EW-1:0]     rnd_exp;

`ifdef FP_ADDSUB_RNE_EN
    // Increment when the discarded part exceeds half an ulp, or equals it with an odd LSB.
    function automatic logic rne_increment(input logic [GW-1:0] m);
        rne_increment = m[2] & (m[3] | m[1] | m[0]);
    endfunction
    assign rnd_up = rne_increment(mbig_q);
`else
    assign rnd_up = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Unpack operands, classify specials, order by magnitude and size the alignment.
    always_comb begin
        sa       = a[FW-1];
        sb_eff   = b[FW-1] ^ op;
        ea       = a[FW-2:MAN_W];
        eb       = b[FW-2:MAN_W];
        fa       = a[MAN_W-1:0];
        fb       = b[MAN_W-1:0];
        ea_eff   = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff   = (eb == '0) ? EXP_W'(1) : eb;
        ma       = {(ea != '0), fa, 3'b000};
        mb       = {(eb != '0), fb, 3'b000};
        a_nan    = (ea == EXP_ONES) && (fa != '0);
        b_nan    = (eb == EXP_ONES) && (fb != '0);
        a_inf    = (ea == EXP_ONES) && (fa == '0);
        b_inf    = (eb == EXP_ONES) && (fb == '0);
        special  = a_nan || b_nan || a_inf || b_inf;
        a_big    = ({ea_eff, ma} >= {eb_eff, mb});
        d        = a_big ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
        cnt_init = (int'(d) > MAN_W + 3) ? CNT_MAX : d[CW-1:0];
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb_eff))) begin
            spec_res = QNAN;
        end else if (a_inf) begin
            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_res = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // Magnitude add/subtract and the rounding increment with its renormalisation.
    always_comb begin
        add_sum   = sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q})
                          : ({1'b0, mbig_q} + {1'b0, msml_q});
        rnd_sum   = {1'b0, mbig_q[GW-1:3]} + {{MW{1'b0}}, rnd_up};
        rnd_carry = rnd_sum[MW];
        rnd_man   = rnd_carry ? rnd_sum[MW:1] : rnd_sum[MW-1:0];
        rnd_exp   = rnd_carry ? (exp_q + EXP_ONE) : exp_q;
    end

    // Next-state and datapath register updates for each FSM state.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        zsign_d  = zsign_q;
        zops_d   = zops_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        mbig_d   = mbig_q;
        msml_d   = msml_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        result_d = spec_res;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        sign_d  = a_big ? sa : sb_eff;
                        zsign_d = sa & sb_eff;
                        zops_d  = (ma == '0) && (mb == '0);
                        sub_d   = sa ^ sb_eff;
                        exp_d   = {2'b00, (a_big ? ea_eff : eb_eff)};
                        mbig_d  = a_big ? ma : mb;
                        msml_d  = a_big ? mb : ma;
                        cnt_d   = cnt_init;
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (cnt_q != '0) begin
                    msml_d = {1'b0, msml_q[GW-1:2], (msml_q[1] | msml_q[0])};
                    cnt_d  = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = ADD;
                end
            end

            ADD: begin
                if (add_sum[GW]) begin
                    mbig_d = {add_sum[GW:2], (add_sum[1] | add_sum[0])};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mbig_d = add_sum[GW-1:0];
                end
                state_d = NORM;
            end

            NORM: begin
                if (!mbig_q[GW-1] && (exp_q > EXP_ONE)) begin
                    mbig_d = {mbig_q[GW-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                    if (mbig_q[GW-2] || (exp_q == EXP_TWO)) begin
                        state_d = ROUND;
                    end
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                if (rnd_man[MW-1] && (rnd_exp >= EXP_MAX)) begin
                    result_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                end else if (!rnd_man[MW-1]) begin
                    result_d = {((rnd_man == '0) ? zsign_q : sign_q), {EXP_W{1'b0}},
                                rnd_man[MAN_W-1:0]};
                    ovf_d    = 1'b0;
                    unf_d    = !zops_q;
                end else begin
                    result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_man[MAN_W-1:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            zsign_q  <= 1'b0;
            zops_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            mbig_q   <= '0;
            msml_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            zsign_q  <= zsign_d;
            zops_q   <= zops_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            mbig_q   <= mbig_d;
            msml_q   <= msml_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (hidden bit excluded).
REQ-003 SHALL have ports: clk input 1, rising-edge clock.
REQ-004 rst_n input 1, synchronous active-low reset.
REQ-005 in_valid input 1, operand pair valid.
REQ-006 in_ready output 1, block can accept an operand pair.
REQ-007 a, b inputs 1+EXP_W+MAN_W each, IEEE-754-style operands {sign, exp, frac}.
REQ-008 op input 1, 0 = a+b, 1 = a-b; sampled with a, b.
REQ-009 out_valid output 1; out_ready input 1.
REQ-010 result output 1+EXP_W+MAN_W; overflow, underflow outputs 1 each.

Function
REQ-011 SHALL accept an operation on the rising edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE, so one operation is in flight at a time.
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-013 On acceptance: capture unpacked operands (hidden bit 1 if exp != 0; exp 0 treated as exponent 1 with hidden bit 0), invert b sign if op=1, order by magnitude, go to ALIGN.
REQ-014 ALIGN SHALL shift the smaller mantissa right one bit per cycle, OR-ing shifted-out bits into sticky. It SHALL occupy a = max(1, min(d, MAN_W+3)) cycles, d = exponent difference.
REQ-015 ADD SHALL add or subtract magnitudes in 1 cycle; a carry-out SHALL shift right 1 and increment exponent within ADD.
REQ-016 NORM SHALL shift left one bit per cycle until the hidden bit is 1 or the exponent reaches 1; it SHALL occupy n = max(1, shift count) cycles.
REQ-017 ROUND SHALL take 1 cycle; a rounding carry to 2.0 SHALL renormalise (shift right, exponent+1).
REQ-018 out_valid SHALL rise exactly 2+a+n rising edges after the accepting edge.
REQ-019 In DONE, result/overflow/underflow SHALL be held stable while out_valid && !out_ready. Transfer completes on an edge with out_valid && out_ready, which returns the FSM to IDLE. in_valid during DONE SHALL be ignored.
REQ-020 Special operands SHALL bypass to DONE, with out_valid 1 edge after acceptance:
- NaN input, or inf + (-inf) after op: canonical NaN (sign 0, exp all-ones, frac MSB 1, rest 0).
- Single or same-sign inf: that inf.
REQ-021 Exact zero result SHALL be +0, except (-0)+(-0) = -0.
REQ-022 Overflow: if the final exponent reaches all-ones, result SHALL be signed inf (frac 0) and overflow=1.
REQ-023 Underflow: if the final result is subnormal or zero from non-zero operands (exp field 0), underflow SHALL be 1.
REQ-024 overflow and underflow SHALL be 0 for special-operand results.

Reset
REQ-025 While rst_n=0 at a rising edge: FSM -> IDLE, out_valid=0, result=0, overflow=0, underflow=0, sticky/internal registers cleared.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after reset release.
REQ-027 Reset in any state, including mid-ALIGN/NORM or DONE with a pending result, SHALL abort the operation; no out_valid for it ever.

Configuration
REQ-028 Macro FP_ADDSUB_RNE_EN defined: ROUND SHALL apply round-to-nearest-even using guard, round and sticky bits.
REQ-029 Macro FP_ADDSUB_RNE_EN undefined: ROUND SHALL truncate (discard guard/round/sticky); state timing SHALL be identical in both builds.

Verification (EXP_W=8, MAN_W=23)
REQ-030 a=3F800000, b=3F000000, op=0 -> result 3FC00000, flags 0, out_valid 4 edges after accept; a=3F800000, b=3F000000, op=1 -> 3F000000, 4 edges.
REQ-031 a=40B9999A, b=C0933333, op=0 -> 3F99999C, out_valid 5 edges after accept, both builds.
REQ-032 a=3F800000, b=33C00000 -> RNE build 3F800001, truncation build 3F800000; out_valid 27 edges after accept (a=24, n=1).
REQ-033 Boundaries:
- 7F7FFFFF+7F7FFFFF -> 7F800000, overflow=1.
- 00000001+00000001 -> 00000002, underflow=1.
- 7F800000+FF800000 -> 7FC00000, 1 edge.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Assert rst_n=0 during ALIGN -> out_valid never rises for that operation and in_ready=1 after release.
